// File: rtl/sr_latch_driver_if.sv
// Signal bundle between the push-button side and the gated SR latch stimulus stage.
// master drives the raw buttons and observes the latch drive; slave is the driver itself.
interface sr_latch_driver_if;
  logic SET_BTN;
  logic RST_BTN;
  logic S;
  logic R;
  logic E;
  logic BUSY;
  logic ERR;
  logic EXP_Q;
  logic EXP_QV;

  modport master (
    output SET_BTN, RST_BTN,
    input  S, R, E, BUSY, ERR, EXP_Q, EXP_QV
  );

  modport slave (
    input  SET_BTN, RST_BTN,
    output S, R, E, BUSY, ERR, EXP_Q, EXP_QV
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Debounces two raw push-buttons and turns each clean press into a setup/strobe/hold
// sequence on the S, R, E inputs of a gated SR latch; all cycle counts lie in 1..2^CW-1.
module sr_latch_driver #(
  parameter int unsigned DB_CYCLES    = 4,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned CW           = 8
) (
  input  logic               clk,
  input  logic               rst,
  sr_latch_driver_if.slave   bus
);

  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  // Bit 0 carries the set button, bit 1 the reset button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_prev;
  logic [1:0]    press;
  logic [CW-1:0] dbcnt [2];

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] ph_cnt;
  logic [CW-1:0] ph_cnt_nxt;
  logic          cmd;
  logic          cmd_nxt;

  logic          s_q;
  logic          r_q;
  logic          e_q;
  logic          busy_q;
  logic          err_q;
  logic          expq_q;
  logic          expqv_q;
  logic          s_nxt;
  logic          r_nxt;
  logic          e_nxt;
  logic          busy_nxt;
  logic          err_nxt;
  logic          expq_nxt;
  logic          expqv_nxt;

  assign btn_raw = {bus.RST_BTN, bus.SET_BTN};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        dbcnt[i] <= '0;
      end
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (dbcnt[i] == DB_LAST) begin
            db[i]    <= ~db[i];
            dbcnt[i] <= '0;
          end else begin
            dbcnt[i] <= dbcnt[i] + 1'b1;
          end
        end else begin
          dbcnt[i] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ph_cnt  <= '0;
      cmd     <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      expq_q  <= 1'b0;
      expqv_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ph_cnt  <= ph_cnt_nxt;
      cmd     <= cmd_nxt;
      s_q     <= s_nxt;
      r_q     <= r_nxt;
      e_q     <= e_nxt;
      busy_q  <= busy_nxt;
      err_q   <= err_nxt;
      expq_q  <= expq_nxt;
      expqv_q <= expqv_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ph_cnt_nxt = ph_cnt;
    cmd_nxt    = cmd;
    err_nxt    = 1'b0;
    expq_nxt   = expq_q;
    expqv_nxt  = expqv_q;

    case (state)
      IDLE: begin
        ph_cnt_nxt = '0;
        if (press == 2'b11) begin
          err_nxt = 1'b1;
        end else if (press != 2'b00) begin
          cmd_nxt   = press[0];
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (ph_cnt == SETUP_LAST) begin
          state_nxt  = STROBE;
          ph_cnt_nxt = '0;
        end else begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end
      end
      STROBE: begin
        if (ph_cnt == PULSE_LAST) begin
          state_nxt  = HOLD;
          ph_cnt_nxt = '0;
          expq_nxt   = cmd;
          expqv_nxt  = 1'b1;
        end else begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (ph_cnt == HOLD_LAST) begin
          state_nxt  = IDLE;
          ph_cnt_nxt = '0;
        end else begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        ph_cnt_nxt = '0;
      end
    endcase

    // Latch drive is decoded from the next state so S/R/E leave flops in step with the FSM.
    busy_nxt = (state_nxt != IDLE);
    s_nxt    = busy_nxt && cmd_nxt;
    r_nxt    = busy_nxt && !cmd_nxt;
    e_nxt    = (state_nxt == STROBE);
  end

  assign bus.S      = s_q;
  assign bus.R      = r_q;
  assign bus.E      = e_q;
  assign bus.BUSY   = busy_q;
  assign bus.ERR    = err_q;
  assign bus.EXP_Q  = expq_q;
  assign bus.EXP_QV = expqv_q;

  a_sr_exclusive: assert property (@(posedge clk) disable iff (rst) !(s_q && r_q));
  a_sr_stable_in_strobe: assert property (@(posedge clk) disable iff (rst)
    (e_q && state_nxt == STROBE) |-> (s_nxt == s_q && r_nxt == r_q));

endmodule
